// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer slice.
package uart_rx_pkg;

    // Sequencer states, in order of the receive handshake with the receiver.
    typedef enum logic [1:0] {
        S_RXS_DISABLED   = 2'd0,
        S_RXS_IDLE       = 2'd1,
        S_RXS_UNLOAD     = 2'd2,
        S_RXS_WAIT_EMPTY = 2'd3
    } rx_state_e;

    // 50 MHz / (115200 baud * 16 oversamples), rounded to the nearest integer.
    localparam int unsigned DEFAULT_DIVISOR = 27;

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Byte-wide synchronous FIFO that buffers received bytes for the stream interface.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_rx_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     Clk,
    input  logic                     Resetn,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [LW-1:0] level_q;
    logic          doPush;
    logic          doPop;
    logic          isEmpty;
    logic          isFull;

    assign isEmpty = (level_q == '0);
    assign isFull  = (level_q == LW'(DEPTH));
    assign doPop   = pop_i && !isEmpty;
    assign doPush  = push_i && (!isFull || doPop);

    // Storage array is not reset; the output is gated so an empty FIFO always presents 0.
    always_ff @(posedge Clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers advance on accepted pushes/pops and wrap naturally at the power-of-two depth;
    // the level tracks occupancy and stays put when a push and pop coincide.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign data_o  = isEmpty ? 8'h00 : mem_q[rdPtr_q];
    assign full_o  = isFull;
    assign empty_o = isEmpty;
    assign level_o = level_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampling baud generator, receiver unload handshake,
// byte FIFO toward a valid/ready stream, and sticky/saturating error status.
module uart_rx_sequencer
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          Clk,
    input  logic                          Resetn,
    input  logic                          cfg_enable,
    input  logic [DIV_WIDTH-1:0]          cfg_divisor,
    input  logic                          cfg_clear_status,
    output logic                          baud_tick,
    output logic                          rx_enable,
    output logic                          rx_unload,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_empty,
    input  logic                          rx_overrun,
    input  logic                          rx_frame_error,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sticky_overrun,
    output logic [CNT_WIDTH-1:0]          frame_err_count,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    logic [DIV_WIDTH-1:0] baudCnt_q;
    logic [DIV_WIDTH-1:0] divLast;
    logic                 baudTick_q;
    logic                 rxEnable_q;
    rx_state_e            state_q;
    logic                 rxUnload_q;

    logic                 fifoPush;
    logic                 fifoPop;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 dropEvent;

    logic                 frameErrPrev_q;
    logic                 overrunPrev_q;
    logic                 frameRise;
    logic                 overrunRise;
    logic [CNT_WIDTH-1:0] frameErrCount_q;
    logic [CNT_WIDTH-1:0] frameErrCount_d;
    logic [CNT_WIDTH-1:0] dropCount_q;
    logic [CNT_WIDTH-1:0] dropCount_d;
    logic                 stickyOverrun_q;
    logic                 stickyOverrun_d;

    // A divisor of 0 behaves like 1, so the terminal count is clamped at 0.
    assign divLast = (cfg_divisor == '0) ? '0 : (cfg_divisor - DIV_WIDTH'(1));

    // Baud counter runs 0..D-1 and strobes the tick on the wrap; the >= compare makes a
    // shrinking divisor wrap immediately instead of running all the way around.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            baudCnt_q  <= '0;
            baudTick_q <= 1'b0;
        end else if (!cfg_enable) begin
            baudCnt_q  <= '0;
            baudTick_q <= 1'b0;
        end else if (baudCnt_q >= divLast) begin
            baudCnt_q  <= '0;
            baudTick_q <= 1'b1;
        end else begin
            baudCnt_q  <= baudCnt_q + DIV_WIDTH'(1);
            baudTick_q <= 1'b0;
        end
    end

    // Receiver enable is simply the configuration bit delayed by one register.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            rxEnable_q <= 1'b0;
        end else begin
            rxEnable_q <= cfg_enable;
        end
    end

    // Unload handshake FSM; the unload strobe is registered alongside the state so it is
    // high exactly while the state is UNLOAD. Dropping the enable wins over everything.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q    <= S_RXS_DISABLED;
            rxUnload_q <= 1'b0;
        end else if (!cfg_enable) begin
            state_q    <= S_RXS_DISABLED;
            rxUnload_q <= 1'b0;
        end else begin
            rxUnload_q <= 1'b0;
            case (state_q)
                S_RXS_DISABLED: begin
                    state_q <= S_RXS_IDLE;
                end
                S_RXS_IDLE: begin
                    if (!rx_empty) begin
                        state_q    <= S_RXS_UNLOAD;
                        rxUnload_q <= 1'b1;
                    end
                end
                S_RXS_UNLOAD: begin
                    state_q <= S_RXS_WAIT_EMPTY;
                end
                S_RXS_WAIT_EMPTY: begin
                    if (rx_empty) begin
                        state_q <= S_RXS_IDLE;
                    end
                end
                default: begin
                    state_q <= S_RXS_DISABLED;
                end
            endcase
        end
    end

    // The byte is taken during the UNLOAD cycle even if the enable is dropping that cycle.
    assign fifoPush  = (state_q == S_RXS_UNLOAD);
    assign fifoPop   = !fifoEmpty && m_ready;
    assign dropEvent = fifoPush && fifoFull && !fifoPop;

    uart_rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .push_i  (fifoPush),
        .data_i  (rx_data),
        .pop_i   (fifoPop),
        .data_o  (m_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    assign frameRise   = rx_frame_error && !frameErrPrev_q;
    assign overrunRise = rx_overrun && !overrunPrev_q;

    // Next status values: a clear wipes everything and swallows any same-cycle event;
    // otherwise counters step on their event and stick at all-ones.
    always_comb begin
        frameErrCount_d = frameErrCount_q;
        dropCount_d     = dropCount_q;
        stickyOverrun_d = stickyOverrun_q;
        if (cfg_clear_status) begin
            frameErrCount_d = '0;
            dropCount_d     = '0;
            stickyOverrun_d = 1'b0;
        end else begin
            if (frameRise && !(&frameErrCount_q)) begin
                frameErrCount_d = frameErrCount_q + CNT_WIDTH'(1);
            end
            if (dropEvent && !(&dropCount_q)) begin
                dropCount_d = dropCount_q + CNT_WIDTH'(1);
            end
            if (overrunRise) begin
                stickyOverrun_d = 1'b1;
            end
        end
    end

    // Register the flag history for edge detection and the status values themselves.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            frameErrPrev_q  <= 1'b0;
            overrunPrev_q   <= 1'b0;
            frameErrCount_q <= '0;
            dropCount_q     <= '0;
            stickyOverrun_q <= 1'b0;
        end else begin
            frameErrPrev_q  <= rx_frame_error;
            overrunPrev_q   <= rx_overrun;
            frameErrCount_q <= frameErrCount_d;
            dropCount_q     <= dropCount_d;
            stickyOverrun_q <= stickyOverrun_d;
        end
    end

    assign baud_tick       = baudTick_q;
    assign rx_enable       = rxEnable_q;
    assign rx_unload       = rxUnload_q;
    assign m_valid         = !fifoEmpty;
    assign sticky_overrun  = stickyOverrun_q;
    assign frame_err_count = frameErrCount_q;
    assign drop_count      = dropCount_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed-plus-random bench for uart_rx_sequencer, checked against a queue-based model.
module tb_uart_rx_sequencer;

    localparam int DEPTH   = 16;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = 255;

    logic          Clk = 1'b0;
    logic          Resetn;
    logic          cfg_enable;
    logic [15:0]   cfg_divisor;
    logic          cfg_clear_status;
    logic          baud_tick;
    logic          rx_enable;
    logic          rx_unload;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic          rx_overrun;
    logic          rx_frame_error;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] fifo_level;
    logic          sticky_overrun;
    logic [7:0]    frame_err_count;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus plain integer status counters.
    logic [7:0] modelQ[$];
    int         modelDrop   = 0;
    int         modelFrame  = 0;
    bit         modelSticky = 1'b0;

    always #5 Clk = ~Clk;

    uart_rx_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (16),
        .CNT_WIDTH  (8)
    ) dut (
        .Clk              (Clk),
        .Resetn           (Resetn),
        .cfg_enable       (cfg_enable),
        .cfg_divisor      (cfg_divisor),
        .cfg_clear_status (cfg_clear_status),
        .baud_tick        (baud_tick),
        .rx_enable        (rx_enable),
        .rx_unload        (rx_unload),
        .rx_data          (rx_data),
        .rx_empty         (rx_empty),
        .rx_overrun       (rx_overrun),
        .rx_frame_error   (rx_frame_error),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .fifo_level       (fifo_level),
        .sticky_overrun   (sticky_overrun),
        .frame_err_count  (frame_err_count),
        .drop_count       (drop_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare every FIFO/status output against the model.
    task automatic checkModel(input string where);
        checkOutput({where, ":level"}, 32'(fifo_level), modelQ.size());
        checkOutput({where, ":valid"}, 32'(m_valid), (modelQ.size() > 0) ? 1 : 0);
        checkOutput({where, ":data"}, 32'(m_data), (modelQ.size() > 0) ? 32'(modelQ[0]) : 0);
        checkOutput({where, ":drop"}, 32'(drop_count), modelDrop);
        checkOutput({where, ":frame"}, 32'(frame_err_count), modelFrame);
        checkOutput({where, ":sticky"}, 32'(sticky_overrun), 32'(modelSticky));
    endtask

    function automatic void modelPush(input logic [7:0] b);
        if (modelQ.size() < DEPTH) modelQ.push_back(b);
        else if (modelDrop < CNT_MAX) modelDrop++;
    endfunction

    // Receiver model: present one byte, expect exactly one unload, raise Empty after it.
    task automatic applyStimulus(input logic [7:0] b, input bit popAtPush);
        bit seen;
        int extra;
        @(negedge Clk);
        rx_data  = b;
        rx_empty = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (rx_unload) seen = 1'b1;
        end
        checkOutput("unload_seen", 32'(seen), 1);
        if (popAtPush) m_ready = 1'b1;
        @(posedge Clk);
        #1;
        rx_empty = 1'b1;
        m_ready  = 1'b0;
        if (popAtPush && modelQ.size() > 0) void'(modelQ.pop_front());
        modelPush(b);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (rx_unload) extra++;
        end
        checkOutput("single_unload", extra, 0);
        checkModel("push");
    endtask

    // Read the whole FIFO out, comparing each head byte to the model in order.
    task automatic drainAll();
        for (int i = 0; i < DEPTH + 2 && modelQ.size() > 0; i++) begin
            @(negedge Clk);
            checkOutput("drain_valid", 32'(m_valid), 1);
            checkOutput("drain_data", 32'(m_data), 32'(modelQ[0]));
            m_ready = 1'b1;
            @(posedge Clk);
            #1;
            m_ready = 1'b0;
            void'(modelQ.pop_front());
        end
        @(negedge Clk);
        checkModel("drained");
    endtask

    // Restart the baud generator from zero with a new divisor and time its ticks.
    task automatic measureBaud(input logic [15:0] div);
        int expD;
        int first;
        int gap;
        expD = (div == 0) ? 1 : int'(div);
        @(negedge Clk);
        cfg_enable = 1'b0;
        repeat (2) @(negedge Clk);
        cfg_divisor = div;
        cfg_enable  = 1'b1;
        first = 0;
        for (int i = 1; i <= 100 && first == 0; i++) begin
            @(posedge Clk);
            #1;
            if (baud_tick) first = i;
        end
        checkOutput("baud_first", first, expD);
        for (int g = 0; g < 2; g++) begin
            gap = 0;
            for (int i = 1; i <= 100 && gap == 0; i++) begin
                @(posedge Clk);
                #1;
                if (baud_tick) gap = i;
            end
            checkOutput("baud_gap", gap, expD);
        end
    endtask

    task automatic pulseFlag(input bit isOverrun, input int width);
        @(negedge Clk);
        if (isOverrun) rx_overrun = 1'b1; else rx_frame_error = 1'b1;
        repeat (width) @(negedge Clk);
        rx_overrun     = 1'b0;
        rx_frame_error = 1'b0;
        @(negedge Clk);
        if (isOverrun) modelSticky = 1'b1;
        else if (modelFrame < CNT_MAX) modelFrame++;
    endtask

    task automatic clearStatus();
        @(negedge Clk);
        cfg_clear_status = 1'b1;
        @(negedge Clk);
        cfg_clear_status = 1'b0;
        modelFrame  = 0;
        modelDrop   = 0;
        modelSticky = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  ticks;
        int  n;
        bit  seen;
        logic [7:0] b;

        Resetn           = 1'b0;
        cfg_enable       = 1'b0;
        cfg_divisor      = 16'd27;
        cfg_clear_status = 1'b0;
        rx_data          = 8'h00;
        rx_empty         = 1'b1;
        rx_overrun       = 1'b0;
        rx_frame_error   = 1'b0;
        m_ready          = 1'b0;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_tick", 32'(baud_tick), 0);
        checkOutput("rst_rxen", 32'(rx_enable), 0);
        checkOutput("rst_unload", 32'(rx_unload), 0);
        checkModel("reset");
        @(negedge Clk);
        Resetn = 1'b1;

        // Baud generator: nominal, zero divisor, random divisor
        measureBaud(16'd27);
        measureBaud(16'd0);
        measureBaud(16'($urandom_range(40, 2)));

        // Disabled: no ticks, receiver enable low
        @(negedge Clk);
        cfg_enable = 1'b0;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk);
            #1;
            if (baud_tick) ticks++;
        end
        checkOutput("dis_ticks", ticks, 0);
        checkOutput("dis_rxen", 32'(rx_enable), 0);

        // Enable and let the FSM settle into IDLE
        @(negedge Clk);
        cfg_divisor = 16'd27;
        cfg_enable  = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("en_rxen", 32'(rx_enable), 1);

        // Single byte 0xA5: unload during the first cycle, data valid after the second edge
        rx_data  = 8'hA5;
        rx_empty = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("a5_unload", 32'(rx_unload), 1);
        checkOutput("a5_valid_early", 32'(m_valid), 0);
        @(posedge Clk);
        #1;
        rx_empty = 1'b1;
        modelPush(8'hA5);
        checkOutput("a5_unload_off", 32'(rx_unload), 0);
        checkModel("a5");
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (rx_unload) n++;
        end
        checkOutput("a5_no_extra", n, 0);
        drainAll();

        // Overfill: 17 random bytes with the consumer stalled
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'($urandom_range(255, 0)), 1'b0);
        checkOutput("full_level", 32'(fifo_level), DEPTH);
        checkOutput("full_drop", 32'(drop_count), 1);
        // Push while popping at full: no drop, level stays at depth
        applyStimulus(8'($urandom_range(255, 0)), 1'b1);
        checkOutput("pushpop_level", 32'(fifo_level), DEPTH);
        checkOutput("pushpop_drop", 32'(drop_count), 1);
        drainAll();

        // Error status: three frame errors, one overrun
        clearStatus();
        for (int i = 0; i < 3; i++) pulseFlag(1'b0, $urandom_range(3, 1));
        pulseFlag(1'b1, $urandom_range(3, 1));
        checkModel("errs3");
        checkOutput("errs3_frame", 32'(frame_err_count), 3);
        checkOutput("errs3_sticky", 32'(sticky_overrun), 1);

        // Clear coinciding with a fourth edge: the event is lost
        @(negedge Clk);
        cfg_clear_status = 1'b1;
        rx_frame_error   = 1'b1;
        rx_overrun       = 1'b1;
        @(negedge Clk);
        cfg_clear_status = 1'b0;
        @(negedge Clk);
        rx_frame_error = 1'b0;
        rx_overrun     = 1'b0;
        @(negedge Clk);
        modelFrame  = 0;
        modelDrop   = 0;
        modelSticky = 1'b0;
        checkModel("clear_edge");

        // Random number of frame errors
        n = $urandom_range(10, 1);
        for (int i = 0; i < n; i++) pulseFlag(1'b0, $urandom_range(2, 1));
        checkModel("errs_rand");

        // Saturation after 300 edges
        clearStatus();
        for (int i = 0; i < 300; i++) pulseFlag(1'b0, 1);
        checkModel("errs_sat");
        checkOutput("sat_value", 32'(frame_err_count), CNT_MAX);

        // Drop enable while in WAIT_EMPTY: disabled next cycle, FIFO intact
        applyStimulus(8'($urandom_range(255, 0)), 1'b0);
        applyStimulus(8'($urandom_range(255, 0)), 1'b0);
        b = 8'($urandom_range(255, 0));
        @(negedge Clk);
        rx_data  = b;
        rx_empty = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (rx_unload) seen = 1'b1;
        end
        checkOutput("we_unload_seen", 32'(seen), 1);
        @(posedge Clk);
        #1;
        modelPush(b);
        @(negedge Clk);
        cfg_enable = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("we_rxen", 32'(rx_enable), 0);
        checkOutput("we_unload", 32'(rx_unload), 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (rx_unload) n++;
        end
        checkOutput("we_no_unload", n, 0);
        checkModel("we_fifo");
        rx_empty = 1'b1;
        @(negedge Clk);
        cfg_enable = 1'b1;
        repeat (2) @(negedge Clk);
        drainAll();

        // Reset asserted mid-UNLOAD: everything back to zero on the next edge
        applyStimulus(8'($urandom_range(255, 0)), 1'b0);
        pulseFlag(1'b0, 1);
        @(negedge Clk);
        rx_data  = 8'($urandom_range(255, 0));
        rx_empty = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (rx_unload) seen = 1'b1;
        end
        checkOutput("rst_mid_seen", 32'(seen), 1);
        Resetn = 1'b0;
        @(posedge Clk);
        #1;
        modelQ.delete();
        modelDrop   = 0;
        modelFrame  = 0;
        modelSticky = 1'b0;
        checkOutput("rstmid_tick", 32'(baud_tick), 0);
        checkOutput("rstmid_rxen", 32'(rx_enable), 0);
        checkOutput("rstmid_unload", 32'(rx_unload), 0);
        checkModel("rstmid");
        @(negedge Clk);
        Resetn   = 1'b1;
        rx_empty = 1'b1;
        repeat (2) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Sequencer and buffer for the UART receive controller. It generates the 16x oversampling `baud_tick` from a programmable divisor, drives the receiver's `Enable`/`Unload_data` inputs, and drains every received byte into an internal FIFO. The FIFO feeds a valid/ready byte stream. Receiver error flags are turned into sticky status bits and saturating counters for the register layer above.

## Interface
- `FIFO_DEPTH`, 16, byte FIFO depth; power of two, ≥2.
- `DIV_WIDTH`, 16, width of baud divisor.
- `CNT_WIDTH`, 8, width of error/drop counters.
---
- `Clk` in 1: sole clock.
- `Resetn` in 1: reset, synchronous, active-low.
- `cfg_enable` in 1: receive path enable.
- `cfg_divisor` in DIV_WIDTH: Clk cycles per `baud_tick`; 0 treated as 1.
- `cfg_clear_status` in 1: one-cycle pulse, clears sticky bits and counters.
- `baud_tick` out 1: one-cycle oversample strobe to receiver.
- `rx_enable` out 1: to receiver `Enable`.
- `rx_unload` out 1: to receiver `Unload_data`.
- `rx_data` in 8: receiver `RX_data`.
- `rx_empty` in 1: receiver `Empty`.
- `rx_overrun` in 1: receiver `Overrun`.
- `rx_frame_error` in 1: receiver `Frame_error`.
- `m_data` out 8: FIFO head byte.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts `m_data`.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `sticky_overrun` out 1: receiver overrun seen since last clear.
- `frame_err_count` out CNT_WIDTH: saturating count of frame errors.
- `drop_count` out CNT_WIDTH: saturating count of bytes lost to a full FIFO.

## Operation
- Reset: all outputs 0 except `m_data` (0); state DISABLED; FIFO empty; baud counter 0.
- Baud generator:
  - Counter runs 0..D-1, where D = max(`cfg_divisor`, 1).
  - `baud_tick` is registered and high for the one cycle after the counter equals D-1; the counter then wraps to 0.
  - While `cfg_enable`=0, the counter is held at 0 and `baud_tick`=0.
  - A divisor change takes effect at the next wrap. If the counter is already ≥ the new D-1, it wraps at the next cycle.
- `rx_enable` is a registered copy of `cfg_enable`.
- FSM, with states DISABLED, IDLE, UNLOAD, WAIT_EMPTY:
  - DISABLED → IDLE when `cfg_enable`=1.
  - IDLE: if `rx_empty`=0 → UNLOAD.
  - UNLOAD, a single cycle:
    - `rx_unload`=1.
    - Push `rx_data` if the FIFO is not full, or if a pop occurs in the same cycle; otherwise increment `drop_count`.
    - Next state is WAIT_EMPTY.
  - WAIT_EMPTY: `rx_unload`=0; → IDLE when `rx_empty`=1.
  - From any state, `cfg_enable`=0 → DISABLED on the next edge. This overrides every other transition.
  - A byte pending in UNLOAD is still pushed in that cycle. FIFO contents are preserved.
- `rx_unload` is a Moore output, high only in UNLOAD. Exactly one pulse is issued per byte.
- FIFO:
  - Pop when `m_valid` && `m_ready`.
  - Simultaneous push and pop leaves the level unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Error status:
  - A rising edge of `rx_frame_error` increments `frame_err_count`. A rising edge of `rx_overrun` sets `sticky_overrun`. Edges are detected against a registered copy of each flag.
  - Counters saturate at all-ones.
  - `cfg_clear_status` has priority over a same-cycle increment or set. The result is 0 and the event is lost.

## Timing
- Receiver `Empty` falls at edge T. The sequencer samples `rx_empty`=0 in IDLE at T+1 and is in UNLOAD at T+1→T+2, so `rx_unload` is high during cycle T+1. The push happens at edge T+2, `m_valid`=1 after T+2, and `fifo_level` updates at T+2.
- Receiver `Empty` rises one cycle after `rx_unload`. WAIT_EMPTY therefore lasts ≥1 cycle before returning to IDLE.
- Pop: `m_data` and `fifo_level` update on the edge where `m_valid` && `m_ready`.
- Status outputs update one cycle after the flag edge is registered.

## Structure
- Package `uart_rx_pkg`: FSM state enum (`S_RXS_DISABLED`, `S_RXS_IDLE`, `S_RXS_UNLOAD`, `S_RXS_WAIT_EMPTY`) and the default divisor constant (50 MHz / (115200·16) = 27).
- Sub-module `uart_rx_byte_fifo`: synchronous FIFO with DEPTH parameter, push/pop, full/empty/level, same synchronous active-low reset.
- Baud generator, FSM and status logic stay in `uart_rx_sequencer`.

## Test plan
- Divisor 27, enable: `baud_tick` pulses exactly every 27 cycles. Divisor 0: pulses every cycle. Disable: no pulses and counter at 0.
- Receiver model presents 0xA5 (Empty falls): exactly one `rx_unload` pulse; `m_valid`=1 with `m_data`=0xA5 two cycles after Empty falls; `fifo_level`=1.
- `m_ready`=0, push 17 bytes into FIFO_DEPTH=16: `fifo_level`=16, `drop_count`=1, first 16 bytes are read out in order. Push during a pop at full: no drop.
- Three `rx_frame_error` pulses and one `rx_overrun`: `frame_err_count`=3, `sticky_overrun`=1. `cfg_clear_status` in the same cycle as a fourth edge: both read 0.
- 300 frame-error edges: `frame_err_count` saturates at 255.
- Drop `cfg_enable` while in WAIT_EMPTY: DISABLED next cycle, `rx_enable`=0, FIFO contents intact. Assert `Resetn`=0 mid-UNLOAD: all outputs 0 and FIFO empty at the next edge.
